// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS IF stage: FSM encoding, the NOP word
// and the word-alignment helper used on every redirect target.
package mips_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

   // sll $0,$0,0
   localparam logic [31:0] NOP_INSTR_WORD  = 32'h0000_0000;
   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction that returned from memory
// while the IF output slot was full and stalled.
module fetch_skid_buffer (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic        i_pop,
   input  logic        i_squash,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc_add,
   output logic        o_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc_add
);

   logic        r_valid;
   logic [31:0] r_instr;
   logic [31:0] r_pc_add;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid  <= 1'b0;
         r_instr  <= '0;
         r_pc_add <= '0;
      end else begin
         // squash wins over a same-cycle load: wrong-path data never survives
         if (i_squash || i_pop) begin
            r_valid <= 1'b0;
         end else if (i_load) begin
            r_valid <= 1'b1;
         end
         if (i_load && !i_squash) begin
            r_instr  <= i_instr;
            r_pc_add <= i_pc_add;
         end
      end
   end

   assign o_valid  = r_valid;
   assign o_instr  = r_instr;
   assign o_pc_add = r_pc_add;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: owns the PC, fetches over a req/ready handshake to a
// variable-latency instruction memory and feeds one slot to IF/ID.
module instruction_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        PCSrc,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        IF_Valid,
   output logic [31:0] IF_PCAddResult,
   output logic [31:0] IF_Instruction,
   output logic        Misalign
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;

   // r_addr is both the PC and the address on the bus; during DRAIN it keeps
   // the abandoned address while r_target holds where to go next.
   logic [31:0] r_addr;
   logic [31:0] w_addr_next;
   logic [31:0] r_target;
   logic [31:0] w_target_next;
   logic        r_imem_req;
   logic        w_imem_req_next;
   logic        r_slot_valid;
   logic        w_slot_valid_next;
   logic [31:0] r_slot_instr;
   logic [31:0] w_slot_instr_next;
   logic [31:0] r_slot_pc_add;
   logic [31:0] w_slot_pc_add_next;
   logic        r_misalign;
   logic        w_misalign_next;

   logic        w_skid_load;
   logic        w_skid_pop;
   logic        w_skid_squash;
   logic        w_skid_valid;
   logic [31:0] w_skid_instr;
   logic [31:0] w_skid_pc_add;

   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_addr_inc;

   // Branch resolves in MEM, so it is older than a jump from ID and wins.
   assign w_redirect = PCSrc | Jump;
   assign w_target   = PCSrc ? BranchTarget : JumpTarget;
   assign w_addr_inc = r_addr + 32'd4;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next       = r_state;
      w_addr_next        = r_addr;
      w_target_next      = r_target;
      w_slot_valid_next  = r_slot_valid;
      w_slot_instr_next  = r_slot_instr;
      w_slot_pc_add_next = r_slot_pc_add;
      w_misalign_next    = r_misalign | (w_redirect & (|w_target[1:0]));
      w_skid_load        = 1'b0;
      w_skid_pop         = 1'b0;
      w_skid_squash      = 1'b0;

      if (w_redirect) begin
         w_slot_valid_next = 1'b0;
         w_skid_squash     = 1'b1;
         if (r_imem_req && !imem_ready) begin
            w_state_next  = DRAIN;
            w_target_next = word_align(w_target);
         end else begin
            w_state_next = FETCH;
            w_addr_next  = word_align(w_target);
         end
      end else begin
         case (r_state)
            IDLE: begin
               w_state_next = FETCH;
            end
            FETCH: begin
               if (imem_ready) begin
                  w_addr_next = w_addr_inc;
                  if (!r_slot_valid || !Stall) begin
                     w_slot_valid_next  = 1'b1;
                     w_slot_instr_next  = imem_rdata;
                     w_slot_pc_add_next = w_addr_inc;
                  end else begin
                     w_skid_load  = 1'b1;
                     w_state_next = HOLD;
                  end
               end else if (!Stall) begin
                  // IF/ID took the slot and nothing replaces it this cycle
                  w_slot_valid_next = 1'b0;
               end
            end
            HOLD: begin
               if (!Stall) begin
                  w_slot_valid_next  = w_skid_valid;
                  w_slot_instr_next  = w_skid_instr;
                  w_slot_pc_add_next = w_skid_pc_add;
                  w_skid_pop         = 1'b1;
                  w_state_next       = FETCH;
               end
            end
            DRAIN: begin
               if (imem_ready) begin
                  w_state_next = FETCH;
                  w_addr_next  = r_target;
               end
            end
         endcase
      end

      w_imem_req_next = (w_state_next == FETCH) || (w_state_next == DRAIN);
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_addr        <= RESET_PC;
         r_target      <= RESET_PC;
         r_imem_req    <= 1'b0;
         r_slot_valid  <= 1'b0;
         r_slot_instr  <= NOP_INSTR;
         r_slot_pc_add <= '0;
         r_misalign    <= 1'b0;
      end else begin
         r_addr        <= w_addr_next;
         r_target      <= w_target_next;
         r_imem_req    <= w_imem_req_next;
         r_slot_valid  <= w_slot_valid_next;
         r_slot_instr  <= w_slot_instr_next;
         r_slot_pc_add <= w_slot_pc_add_next;
         r_misalign    <= w_misalign_next;
      end
   end

   fetch_skid_buffer u_skid (
      .i_clk    (Clk),
      .i_rst_n  (Reset),
      .i_load   (w_skid_load),
      .i_pop    (w_skid_pop),
      .i_squash (w_skid_squash),
      .i_instr  (imem_rdata),
      .i_pc_add (w_addr_inc),
      .o_valid  (w_skid_valid),
      .o_instr  (w_skid_instr),
      .o_pc_add (w_skid_pc_add)
   );

   assign imem_req       = r_imem_req;
   assign imem_addr      = r_addr;
   assign IF_Valid       = r_slot_valid;
   assign IF_PCAddResult = r_slot_pc_add;
   assign IF_Instruction = r_slot_valid ? r_slot_instr : NOP_INSTR;
   assign Misalign       = r_misalign;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: scenario tasks plus a
// scoreboard of instructions expected to be handed to IF/ID.
module tb_instruction_fetch_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Stall;
   logic        PCSrc;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        IF_Valid;
   logic [31:0] IF_PCAddResult;
   logic [31:0] IF_Instruction;
   logic        Misalign;

   int checks = 0;
   int errors = 0;

   // expected {pc+4, instruction} in the order IF/ID should receive them
   logic [63:0] sb_q[$];

   always #5 Clk = ~Clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   // instruction memory content follows whatever address is on the bus
   always_comb imem_rdata = mem_word(imem_addr);

   instruction_fetch_unit dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Stall          (Stall),
      .PCSrc          (PCSrc),
      .BranchTarget   (BranchTarget),
      .Jump           (Jump),
      .JumpTarget     (JumpTarget),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .IF_Valid       (IF_Valid),
      .IF_PCAddResult (IF_PCAddResult),
      .IF_Instruction (IF_Instruction),
      .Misalign       (Misalign)
   );

   // IF/ID consumes the slot at an edge with valid, no stall and no flush
   always @(negedge Clk) begin
      if (Reset && IF_Valid && !Stall && !PCSrc && !Jump) begin
         logic [63:0] exp_v;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got pc4=%h instr=%h, expected no instruction", IF_PCAddResult, IF_Instruction);
         end else begin
            exp_v = sb_q.pop_front();
            if ({IF_PCAddResult, IF_Instruction} !== exp_v) begin
               errors++;
               $display("FAIL sb_order: got pc4=%h instr=%h, expected pc4=%h instr=%h",
                        IF_PCAddResult, IF_Instruction, exp_v[63:32], exp_v[31:0]);
            end else begin
               $display("consume pc4=%h instr=%h", IF_PCAddResult, IF_Instruction);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] addr);
      sb_q.push_back({addr + 32'd4, mem_word(addr)});
   endtask

   task automatic test_reset(input int n_edges);
      Reset = 1'b0;
      for (int i = 0; i < n_edges; i++) tick();
      checks += 6;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b, expected 0", imem_req); end
      if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h, expected 0", imem_addr); end
      if (IF_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", IF_Valid); end
      if (IF_Instruction !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h, expected 0", IF_Instruction); end
      if (IF_PCAddResult !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h, expected 0", IF_PCAddResult); end
      if (Misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b, expected 0", Misalign); end
      $display("reset %0d edges: req=%b addr=%h valid=%b", n_edges, imem_req, imem_addr, IF_Valid);
   endtask

   task automatic test_sequential();
      Reset = 1'b1;
      imem_ready = 1'b1;
      tick();
      checks += 3;
      if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req: got %b, expected 1", imem_req); end
      if (imem_addr !== 32'h0) begin errors++; $display("FAIL seq_addr0: got %h, expected 0", imem_addr); end
      if (IF_Valid !== 1'b0) begin errors++; $display("FAIL seq_valid0: got %b, expected 0", IF_Valid); end
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         a = 32'(i * 4);
         push_exp(a);
         if (i == 3) imem_ready = 1'b1;
         tick();
         checks += 2;
         if (IF_Valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b, expected 1", IF_Valid); end
         if (IF_PCAddResult !== a + 32'd4) begin
            errors++; $display("FAIL seq_pc4: got %h, expected %h", IF_PCAddResult, a + 32'd4);
         end
         $display("seq fetch addr=%h pc4=%h", a, IF_PCAddResult);
      end
      imem_ready = 1'b0;
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks += 4;
         if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req: got %b, expected 1", imem_req); end
         if (imem_addr !== 32'h10) begin errors++; $display("FAIL wait_addr: got %h, expected 10", imem_addr); end
         if (IF_Valid !== 1'b0) begin errors++; $display("FAIL wait_valid: got %b, expected 0", IF_Valid); end
         if (IF_Instruction !== 32'h0) begin errors++; $display("FAIL wait_nop: got %h, expected 0", IF_Instruction); end
         $display("wait cycle %0d req=%b addr=%h valid=%b", i, imem_req, imem_addr, IF_Valid);
      end
      imem_ready = 1'b1;
      push_exp(32'h10);
      tick();
      checks += 2;
      if (IF_PCAddResult !== 32'h14) begin errors++; $display("FAIL wait_pc4: got %h, expected 14", IF_PCAddResult); end
      if (IF_Instruction !== mem_word(32'h10)) begin
         errors++; $display("FAIL wait_instr: got %h, expected %h", IF_Instruction, mem_word(32'h10));
      end
      $display("wait done pc4=%h instr=%h", IF_PCAddResult, IF_Instruction);
   endtask

   task automatic test_stall_skid();
      Stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks += 3;
         if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b, expected 0", imem_req); end
         if (IF_PCAddResult !== 32'h14) begin errors++; $display("FAIL hold_pc4: got %h, expected 14", IF_PCAddResult); end
         if (IF_Instruction !== mem_word(32'h10)) begin
            errors++; $display("FAIL hold_instr: got %h, expected %h", IF_Instruction, mem_word(32'h10));
         end
         $display("stall cycle %0d req=%b pc4=%h", i, imem_req, IF_PCAddResult);
      end
      Stall = 1'b0;
      push_exp(32'h14);
      tick();
      checks += 3;
      if (IF_PCAddResult !== 32'h18) begin errors++; $display("FAIL skid_pc4: got %h, expected 18", IF_PCAddResult); end
      if (imem_req !== 1'b1) begin errors++; $display("FAIL skid_req: got %b, expected 1", imem_req); end
      if (imem_addr !== 32'h18) begin errors++; $display("FAIL skid_addr: got %h, expected 18", imem_addr); end
      $display("skid pop pc4=%h next addr=%h", IF_PCAddResult, imem_addr);
      // this slot is flushed by the redirect that follows, so it is not queued
      tick();
      checks++;
      if (IF_PCAddResult !== 32'h1C) begin errors++; $display("FAIL skid_next_pc4: got %h, expected 1c", IF_PCAddResult); end
   endtask

   task automatic test_redirect_priority();
      PCSrc = 1'b1; BranchTarget = 32'h40;
      Jump  = 1'b1; JumpTarget   = 32'h80;
      tick();
      PCSrc = 1'b0; Jump = 1'b0;
      checks += 3;
      if (IF_Valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b, expected 0", IF_Valid); end
      if (IF_Instruction !== 32'h0) begin errors++; $display("FAIL redir_nop: got %h, expected 0", IF_Instruction); end
      if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr: got %h, expected 40", imem_addr); end
      $display("redirect branch+jump -> addr=%h", imem_addr);
      push_exp(32'h40);
      tick();
      checks++;
      if (IF_PCAddResult !== 32'h44) begin errors++; $display("FAIL redir_pc4: got %h, expected 44", IF_PCAddResult); end
      imem_ready = 1'b0;
      tick();
   endtask

   task automatic test_drain();
      Jump = 1'b1; JumpTarget = 32'h20; imem_ready = 1'b1;
      tick();
      Jump = 1'b0; imem_ready = 1'b0;
      checks += 2;
      if (imem_addr !== 32'h20) begin errors++; $display("FAIL same_edge_addr: got %h, expected 20", imem_addr); end
      if (IF_Valid !== 1'b0) begin errors++; $display("FAIL same_edge_valid: got %b, expected 0", IF_Valid); end
      tick();
      Jump = 1'b1; JumpTarget = 32'h180;
      tick();
      Jump = 1'b0;
      PCSrc = 1'b1; BranchTarget = 32'h100;
      checks += 2;
      if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin
         errors++; $display("FAIL drain_hold1: got req=%b addr=%h, expected req=1 addr=20", imem_req, imem_addr);
      end
      if (IF_Valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b, expected 0", IF_Valid); end
      tick();
      PCSrc = 1'b0;
      checks++;
      if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin
         errors++; $display("FAIL drain_hold2: got req=%b addr=%h, expected req=1 addr=20", imem_req, imem_addr);
      end
      imem_ready = 1'b1;
      tick();
      checks += 2;
      if (IF_Valid !== 1'b0) begin errors++; $display("FAIL drain_discard: got %b, expected 0", IF_Valid); end
      if (imem_addr !== 32'h100) begin errors++; $display("FAIL drain_target: got %h, expected 100", imem_addr); end
      $display("drain done -> addr=%h", imem_addr);
      push_exp(32'h100);
      tick();
      checks++;
      if (IF_PCAddResult !== 32'h104) begin errors++; $display("FAIL drain_pc4: got %h, expected 104", IF_PCAddResult); end
      imem_ready = 1'b0;
      tick();
   endtask

   task automatic test_misalign();
      Jump = 1'b1; JumpTarget = 32'h102;
      tick();
      Jump = 1'b0;
      checks++;
      if (Misalign !== 1'b1) begin errors++; $display("FAIL mis_set: got %b, expected 1", Misalign); end
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      checks += 2;
      if (imem_addr !== 32'h100) begin errors++; $display("FAIL mis_addr: got %h, expected 100", imem_addr); end
      if (Misalign !== 1'b1) begin errors++; $display("FAIL mis_sticky1: got %b, expected 1", Misalign); end
      tick();
      checks++;
      if (Misalign !== 1'b1 || imem_req !== 1'b1) begin
         errors++; $display("FAIL mis_sticky2: got mis=%b req=%b, expected 1 1", Misalign, imem_req);
      end
      $display("misalign=%b addr=%h", Misalign, imem_addr);
   endtask

   task automatic test_wrap();
      Reset = 1'b1;
      imem_ready = 1'b0;
      tick();
      Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC; imem_ready = 1'b1;
      tick();
      Jump = 1'b0;
      checks++;
      if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h, expected fffffffc", imem_addr); end
      push_exp(32'hFFFF_FFFC);
      tick();
      checks += 2;
      if (IF_PCAddResult !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h, expected 0", IF_PCAddResult); end
      if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h, expected 0", imem_addr); end
      push_exp(32'h0);
      tick();
      checks++;
      if (IF_PCAddResult !== 32'h4) begin errors++; $display("FAIL wrap_pc4b: got %h, expected 4", IF_PCAddResult); end
      imem_ready = 1'b0;
      tick();
      $display("wrap pc4 sequence ends at %h", IF_PCAddResult);
   endtask

   initial begin
      Reset = 1'b0; Stall = 1'b0; PCSrc = 1'b0; Jump = 1'b0;
      BranchTarget = '0; JumpTarget = '0; imem_ready = 1'b0;
      test_reset(2);
      test_sequential();
      test_mem_wait();
      test_stall_skid();
      test_redirect_priority();
      test_drain();
      test_misalign();
      test_reset(1);
      test_wrap();
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
